// File: rtl/xdma_byp_pkg.sv
// Shared definitions for the XDMA descriptor-bypass issuer.
// Holds the direction encodings, the descriptor control-bit positions,
// the descriptor length width, the descriptor record and the issuer FSM
// state type.
package xdma_byp_pkg;

  localparam logic DIR_H2C = 1'b0;
  localparam logic DIR_C2H = 1'b1;

  localparam int CTL_STOP_BIT = 0;
  localparam int CTL_CMPL_BIT = 1;
  localparam int CTL_EOP_BIT  = 4;

  localparam int DSC_LEN_W = 28;

  typedef struct packed {
    logic [63:0]          src;
    logic [63:0]          dst;
    logic [DSC_LEN_W-1:0] len;
    logic [15:0]          ctl;
  } dsc_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issuer_state_t;

endpackage

// File: rtl/xdma_dsc_chunker.sv
// Splits one copy request into descriptor-sized chunks.
// Holds the remaining byte count and the current source/destination
// addresses of the request being issued, and presents the size of the
// next chunk and whether it is the final one.
//
// Ports:
//   axi_aclk, axi_areset   clock and synchronous active-high reset
//   start                  latch a new request (start_src/dst/len)
//   advance                current chunk was loaded; move to the next one
//   cur_src, cur_dst       addresses of the current chunk
//   chunk_len              byte length of the current chunk
//   last                   current chunk finishes the request
module xdma_dsc_chunker
  import xdma_byp_pkg::*;
#(
  parameter int MAX_CHUNK = 4096
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  input  logic                 start,
  input  logic [63:0]          start_src,
  input  logic [63:0]          start_dst,
  input  logic [31:0]          start_len,
  input  logic                 advance,
  output logic [63:0]          cur_src,
  output logic [63:0]          cur_dst,
  output logic [DSC_LEN_W-1:0] chunk_len,
  output logic                 last
);

  localparam logic [31:0] MAX_CHUNK_W = 32'(MAX_CHUNK);

  logic [31:0] rem_q;
  logic [63:0] src_q;
  logic [63:0] dst_q;

  // The final chunk always fits in the descriptor length field because
  // MAX_CHUNK itself does, so truncating rem is safe once last is set.
  assign last      = (rem_q <= MAX_CHUNK_W);
  assign chunk_len = last ? rem_q[DSC_LEN_W-1:0] : MAX_CHUNK_W[DSC_LEN_W-1:0];
  assign cur_src   = src_q;
  assign cur_dst   = dst_q;

  // Addresses wrap naturally modulo 2^64.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rem_q <= '0;
      src_q <= '0;
      dst_q <= '0;
    end else if (start) begin
      rem_q <= start_len;
      src_q <= start_src;
      dst_q <= start_dst;
    end else if (advance) begin
      rem_q <= rem_q - 32'(chunk_len);
      src_q <= src_q + 64'(chunk_len);
      dst_q <= dst_q + 64'(chunk_len);
    end
  end

endmodule

// File: rtl/xdma_dsc_byp_issuer.sv
// Drives the XDMA channel-0 descriptor-bypass interface from a simple
// copy-request stream. Each request is cut into descriptors of at most
// MAX_CHUNK bytes; the last one carries EOP and completed.
//
// Ports:
//   axi_aclk, axi_areset       clock and synchronous active-high reset
//   req_*                      copy request stream (valid/ready), done/err pulses
//   h2c_dsc_byp_*_0            H2C descriptor bypass (ready in, load + fields out)
//   c2h_dsc_byp_*_0            C2H descriptor bypass (ready in, load + fields out)
//   busy                       a request is being issued
//   h2c_desc_cnt, c2h_desc_cnt wrapping counts of loaded descriptors
module xdma_dsc_byp_issuer
  import xdma_byp_pkg::*;
#(
  parameter int MAX_CHUNK = 4096,
  parameter int CNT_W     = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_dir,
  input  logic [63:0]          req_src_addr,
  input  logic [63:0]          req_dst_addr,
  input  logic [31:0]          req_len,
  output logic                 req_done,
  output logic                 req_err,
  input  logic                 h2c_dsc_byp_ready_0,
  output logic                 h2c_dsc_byp_load_0,
  output logic [63:0]          h2c_dsc_byp_src_addr_0,
  output logic [63:0]          h2c_dsc_byp_dst_addr_0,
  output logic [DSC_LEN_W-1:0] h2c_dsc_byp_len_0,
  output logic [15:0]          h2c_dsc_byp_ctl_0,
  input  logic                 c2h_dsc_byp_ready_0,
  output logic                 c2h_dsc_byp_load_0,
  output logic [63:0]          c2h_dsc_byp_src_addr_0,
  output logic [63:0]          c2h_dsc_byp_dst_addr_0,
  output logic [DSC_LEN_W-1:0] c2h_dsc_byp_len_0,
  output logic [15:0]          c2h_dsc_byp_ctl_0,
  output logic                 busy,
  output logic [CNT_W-1:0]     h2c_desc_cnt,
  output logic [CNT_W-1:0]     c2h_desc_cnt
);

  issuer_state_t        state_q, state_d;
  logic                 dir_q;
  logic                 req_err_q;
  logic [CNT_W-1:0]     h2c_cnt_q, c2h_cnt_q;

  logic                 accept;
  logic                 start;
  logic                 issue;
  logic                 sel_ready;
  logic                 load_any;
  logic                 last;
  logic [63:0]          cur_src, cur_dst;
  logic [DSC_LEN_W-1:0] chunk_len;
  dsc_t                 dsc_cur;
  dsc_t                 h2c_dsc, c2h_dsc;

  // Reset is folded into the handshake so nothing is accepted or loaded
  // in a cycle where the block is being reset.
  assign req_ready = (state_q == ST_IDLE) && !axi_areset;
  assign accept    = req_valid && req_ready;
  assign start     = accept && (req_len != 32'd0);
  assign issue     = (state_q == ST_ISSUE) && !axi_areset;
  assign sel_ready = (dir_q == DIR_C2H) ? c2h_dsc_byp_ready_0 : h2c_dsc_byp_ready_0;
  assign load_any  = issue && sel_ready;

  xdma_dsc_chunker #(
    .MAX_CHUNK(MAX_CHUNK)
  ) u_chunker (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .start     (start),
    .start_src (req_src_addr),
    .start_dst (req_dst_addr),
    .start_len (req_len),
    .advance   (load_any),
    .cur_src   (cur_src),
    .cur_dst   (cur_dst),
    .chunk_len (chunk_len),
    .last      (last)
  );

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_H2C;
      req_err_q <= 1'b0;
      h2c_cnt_q <= '0;
      c2h_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_err_q <= accept && (req_len == 32'd0);
      if (accept) begin
        dir_q <= req_dir;
      end
      if (load_any && (dir_q == DIR_H2C)) begin
        h2c_cnt_q <= h2c_cnt_q + 1'b1;
      end
      if (load_any && (dir_q == DIR_C2H)) begin
        c2h_cnt_q <= c2h_cnt_q + 1'b1;
      end
    end
  end

  // Zero-length requests are consumed in IDLE and only raise req_err.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)            state_d = ST_ISSUE;
      ST_ISSUE: if (load_any && last) state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dsc_cur                   = '0;
    dsc_cur.src               = cur_src;
    dsc_cur.dst               = cur_dst;
    dsc_cur.len               = chunk_len;
    dsc_cur.ctl[CTL_STOP_BIT] = 1'b0;
    dsc_cur.ctl[CTL_CMPL_BIT] = last;
    dsc_cur.ctl[CTL_EOP_BIT]  = last;
  end

  // Only the selected channel sees the descriptor; the other reads zero.
  assign h2c_dsc = (issue && (dir_q == DIR_H2C)) ? dsc_cur : '0;
  assign c2h_dsc = (issue && (dir_q == DIR_C2H)) ? dsc_cur : '0;

  assign h2c_dsc_byp_load_0     = load_any && (dir_q == DIR_H2C);
  assign h2c_dsc_byp_src_addr_0 = h2c_dsc.src;
  assign h2c_dsc_byp_dst_addr_0 = h2c_dsc.dst;
  assign h2c_dsc_byp_len_0      = h2c_dsc.len;
  assign h2c_dsc_byp_ctl_0      = h2c_dsc.ctl;

  assign c2h_dsc_byp_load_0     = load_any && (dir_q == DIR_C2H);
  assign c2h_dsc_byp_src_addr_0 = c2h_dsc.src;
  assign c2h_dsc_byp_dst_addr_0 = c2h_dsc.dst;
  assign c2h_dsc_byp_len_0      = c2h_dsc.len;
  assign c2h_dsc_byp_ctl_0      = c2h_dsc.ctl;

  assign req_done     = load_any && last;
  assign req_err      = req_err_q;
  assign busy         = issue;
  assign h2c_desc_cnt = h2c_cnt_q;
  assign c2h_desc_cnt = c2h_cnt_q;

endmodule

// File: tb/tb_xdma_dsc_byp_issuer.sv
// Self-checking bench for xdma_dsc_byp_issuer. Expected descriptors are
// produced by splitting each request into MAX_CHUNK pieces with plain
// arithmetic; counters are tracked as simple totals.
module tb_xdma_dsc_byp_issuer;

  localparam int MAX_CHUNK = 4096;
  localparam int CNT_W     = 4;

  logic              axi_aclk = 1'b0;
  logic              axi_areset;
  logic              req_valid;
  logic              req_ready;
  logic              req_dir;
  logic [63:0]       req_src_addr;
  logic [63:0]       req_dst_addr;
  logic [31:0]       req_len;
  logic              req_done;
  logic              req_err;
  logic              h2c_dsc_byp_ready_0;
  logic              h2c_dsc_byp_load_0;
  logic [63:0]       h2c_dsc_byp_src_addr_0;
  logic [63:0]       h2c_dsc_byp_dst_addr_0;
  logic [27:0]       h2c_dsc_byp_len_0;
  logic [15:0]       h2c_dsc_byp_ctl_0;
  logic              c2h_dsc_byp_ready_0;
  logic              c2h_dsc_byp_load_0;
  logic [63:0]       c2h_dsc_byp_src_addr_0;
  logic [63:0]       c2h_dsc_byp_dst_addr_0;
  logic [27:0]       c2h_dsc_byp_len_0;
  logic [15:0]       c2h_dsc_byp_ctl_0;
  logic              busy;
  logic [CNT_W-1:0]  h2c_desc_cnt;
  logic [CNT_W-1:0]  c2h_desc_cnt;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] model_h2c = '0;
  logic [CNT_W-1:0] model_c2h = '0;

  xdma_dsc_byp_issuer #(
    .MAX_CHUNK(MAX_CHUNK),
    .CNT_W    (CNT_W)
  ) dut (
    .axi_aclk              (axi_aclk),
    .axi_areset            (axi_areset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_dir               (req_dir),
    .req_src_addr          (req_src_addr),
    .req_dst_addr          (req_dst_addr),
    .req_len               (req_len),
    .req_done              (req_done),
    .req_err               (req_err),
    .h2c_dsc_byp_ready_0   (h2c_dsc_byp_ready_0),
    .h2c_dsc_byp_load_0    (h2c_dsc_byp_load_0),
    .h2c_dsc_byp_src_addr_0(h2c_dsc_byp_src_addr_0),
    .h2c_dsc_byp_dst_addr_0(h2c_dsc_byp_dst_addr_0),
    .h2c_dsc_byp_len_0     (h2c_dsc_byp_len_0),
    .h2c_dsc_byp_ctl_0     (h2c_dsc_byp_ctl_0),
    .c2h_dsc_byp_ready_0   (c2h_dsc_byp_ready_0),
    .c2h_dsc_byp_load_0    (c2h_dsc_byp_load_0),
    .c2h_dsc_byp_src_addr_0(c2h_dsc_byp_src_addr_0),
    .c2h_dsc_byp_dst_addr_0(c2h_dsc_byp_dst_addr_0),
    .c2h_dsc_byp_len_0     (c2h_dsc_byp_len_0),
    .c2h_dsc_byp_ctl_0     (c2h_dsc_byp_ctl_0),
    .busy                  (busy),
    .h2c_desc_cnt          (h2c_desc_cnt),
    .c2h_desc_cnt          (c2h_desc_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Ready pattern per mode: 0 always ready, 1 random, 2 repeating 1,0,0,1.
  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || h2c_dsc_byp_load_0 !== 1'b0 ||
        c2h_dsc_byp_load_0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s idle: busy=%b req_ready=%b h2c_load=%b c2h_load=%b, need 0 1 0 0",
               name, busy, req_ready, h2c_dsc_byp_load_0, c2h_dsc_byp_load_0);
    end
    checks++;
    if (h2c_desc_cnt !== model_h2c || c2h_desc_cnt !== model_c2h) begin
      failures++;
      $display("[TB] FAIL %s counters: h2c=%0d c2h=%0d, need h2c=%0d c2h=%0d",
               name, h2c_desc_cnt, c2h_desc_cnt, model_h2c, model_c2h);
    end
  endtask

  task automatic do_reset();
    @(negedge axi_aclk);
    axi_areset = 1'b1;
    @(negedge axi_aclk);
    axi_areset = 1'b0;
    model_h2c = '0;
    model_c2h = '0;
  endtask

  // Issues one request and checks every descriptor cycle against the
  // expected split of the request.
  task automatic run_request(input logic d, input logic [63:0] s, input logic [63:0] t,
                             input logic [31:0] len, input int mode, input string name);
    logic [63:0] es[$];
    logic [63:0] ed[$];
    logic [27:0] el[$];
    logic [31:0] rem;
    logic [63:0] off;
    logic        r;
    logic        o_load, x_load;
    logic [63:0] o_src, o_dst, x_src, x_dst;
    logic [27:0] o_len, x_len;
    logic [15:0] o_ctl, x_ctl, e_ctl;
    int          n, idx, cyc, budget;

    rem = len;
    off = '0;
    while (rem != 0) begin
      logic [31:0] c;
      c = (rem > MAX_CHUNK) ? 32'(MAX_CHUNK) : rem;
      es.push_back(s + off);
      ed.push_back(t + off);
      el.push_back(c[27:0]);
      off = off + 64'(c);
      rem = rem - c;
    end
    n = es.size();
    budget = 16 + n * 24;

    @(negedge axi_aclk);
    req_valid = 1'b1;
    req_dir = d;
    req_src_addr = s;
    req_dst_addr = t;
    req_len = len;
    h2c_dsc_byp_ready_0 = 1'b0;
    c2h_dsc_byp_ready_0 = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s accept: req_ready=%b, need 1", name, req_ready);
    end
    @(negedge axi_aclk);
    req_valid = 1'b0;

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      r = pick_ready(mode, cyc);
      if (d) begin
        c2h_dsc_byp_ready_0 = r;
        h2c_dsc_byp_ready_0 = 1'($urandom_range(0, 1));
      end else begin
        h2c_dsc_byp_ready_0 = r;
        c2h_dsc_byp_ready_0 = 1'($urandom_range(0, 1));
      end
      #1;
      o_load = d ? c2h_dsc_byp_load_0     : h2c_dsc_byp_load_0;
      o_src  = d ? c2h_dsc_byp_src_addr_0 : h2c_dsc_byp_src_addr_0;
      o_dst  = d ? c2h_dsc_byp_dst_addr_0 : h2c_dsc_byp_dst_addr_0;
      o_len  = d ? c2h_dsc_byp_len_0      : h2c_dsc_byp_len_0;
      o_ctl  = d ? c2h_dsc_byp_ctl_0      : h2c_dsc_byp_ctl_0;
      x_load = d ? h2c_dsc_byp_load_0     : c2h_dsc_byp_load_0;
      x_src  = d ? h2c_dsc_byp_src_addr_0 : c2h_dsc_byp_src_addr_0;
      x_dst  = d ? h2c_dsc_byp_dst_addr_0 : c2h_dsc_byp_dst_addr_0;
      x_len  = d ? h2c_dsc_byp_len_0      : c2h_dsc_byp_len_0;
      x_ctl  = d ? h2c_dsc_byp_ctl_0      : c2h_dsc_byp_ctl_0;
      e_ctl  = (idx == n - 1) ? 16'h0012 : 16'h0000;

      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s issuing: busy=%b req_ready=%b, need 1 0", name, busy, req_ready);
      end
      checks++;
      if (o_src !== es[idx] || o_dst !== ed[idx] || o_len !== el[idx] || o_ctl !== e_ctl) begin
        failures++;
        $display("[TB] FAIL %s desc%0d: src=%h dst=%h len=%0d ctl=%h, need src=%h dst=%h len=%0d ctl=%h",
                 name, idx, o_src, o_dst, o_len, o_ctl, es[idx], ed[idx], el[idx], e_ctl);
      end
      checks++;
      if (o_load !== r) begin
        failures++;
        $display("[TB] FAIL %s load%0d: load=%b, need %b (ready)", name, idx, o_load, r);
      end
      checks++;
      if (x_load !== 1'b0 || x_src !== 64'd0 || x_dst !== 64'd0 || x_len !== 28'd0 ||
          x_ctl !== 16'd0) begin
        failures++;
        $display("[TB] FAIL %s other channel: load=%b src=%h dst=%h len=%0d ctl=%h, need all 0",
                 name, x_load, x_src, x_dst, x_len, x_ctl);
      end
      checks++;
      if (o_load === 1'b1) begin
        if (req_done !== (idx == n - 1)) begin
          failures++;
          $display("[TB] FAIL %s done%0d: req_done=%b, need %b", name, idx, req_done, (idx == n - 1));
        end
        if (d) model_c2h = model_c2h + 1'b1;
        else   model_h2c = model_h2c + 1'b1;
        idx++;
      end else if (req_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s done without load: req_done=%b, need 0", name, req_done);
      end
      cyc++;
      @(negedge axi_aclk);
    end

    checks++;
    if (idx != n) begin
      failures++;
      $display("[TB] FAIL %s timeout: loads=%0d, need %0d", name, idx, n);
    end
    h2c_dsc_byp_ready_0 = 1'b0;
    c2h_dsc_byp_ready_0 = 1'b0;
    #1;
    check_idle_outputs(name);
  endtask

  task automatic test_reset();
    axi_areset = 1'b1;
    req_valid = 1'b0;
    req_dir = 1'b0;
    req_src_addr = '0;
    req_dst_addr = '0;
    req_len = '0;
    h2c_dsc_byp_ready_0 = 1'b1;
    c2h_dsc_byp_ready_0 = 1'b1;
    repeat (3) @(negedge axi_aclk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || h2c_dsc_byp_load_0 !== 1'b0 ||
        c2h_dsc_byp_load_0 !== 1'b0 || req_done !== 1'b0 || req_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset during: req_ready=%b busy=%b loads=%b%b done=%b err=%b, need all 0",
               req_ready, busy, h2c_dsc_byp_load_0, c2h_dsc_byp_load_0, req_done, req_err);
    end
    @(negedge axi_aclk);
    axi_areset = 1'b0;
    #1;
    model_h2c = '0;
    model_c2h = '0;
    check_idle_outputs("reset after");
    checks++;
    if (h2c_dsc_byp_src_addr_0 !== 64'd0 || h2c_dsc_byp_len_0 !== 28'd0 ||
        h2c_dsc_byp_ctl_0 !== 16'd0 || c2h_dsc_byp_dst_addr_0 !== 64'd0 ||
        c2h_dsc_byp_len_0 !== 28'd0 || c2h_dsc_byp_ctl_0 !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset fields: h2c src=%h len=%0d ctl=%h c2h dst=%h len=%0d ctl=%h, need 0",
               h2c_dsc_byp_src_addr_0, h2c_dsc_byp_len_0, h2c_dsc_byp_ctl_0,
               c2h_dsc_byp_dst_addr_0, c2h_dsc_byp_len_0, c2h_dsc_byp_ctl_0);
    end
  endtask

  task automatic test_single_h2c();
    run_request(1'b0, 64'h1000, 64'h0, 32'd100, 0, "single_h2c");
  endtask

  task automatic test_multi_c2h();
    run_request(1'b1, 64'h0, 64'h8000_0000, 32'd10000, 0, "multi_c2h");
  endtask

  task automatic test_stall();
    run_request(1'b0, 64'h2_0000, 64'h3_0000, 32'd8192, 2, "stall_h2c");
  endtask

  task automatic test_zero_len();
    logic [CNT_W-1:0] h_before, c_before;
    h_before = h2c_desc_cnt;
    c_before = c2h_desc_cnt;
    @(negedge axi_aclk);
    req_valid = 1'b1;
    req_dir = 1'b0;
    req_len = 32'd0;
    h2c_dsc_byp_ready_0 = 1'b1;
    c2h_dsc_byp_ready_0 = 1'b1;
    @(negedge axi_aclk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_err !== 1'b1 || req_ready !== 1'b1 || h2c_dsc_byp_load_0 !== 1'b0 ||
        c2h_dsc_byp_load_0 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_len pulse: err=%b ready=%b loads=%b%b busy=%b, need 1 1 00 0",
               req_err, req_ready, h2c_dsc_byp_load_0, c2h_dsc_byp_load_0, busy);
    end
    @(negedge axi_aclk);
    #1;
    checks++;
    if (req_err !== 1'b0 || h2c_desc_cnt !== h_before || c2h_desc_cnt !== c_before) begin
      failures++;
      $display("[TB] FAIL zero_len after: err=%b h2c=%0d c2h=%0d, need 0 %0d %0d",
               req_err, h2c_desc_cnt, c2h_desc_cnt, h_before, c_before);
    end
    h2c_dsc_byp_ready_0 = 1'b0;
    c2h_dsc_byp_ready_0 = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    @(negedge axi_aclk);
    req_valid = 1'b1;
    req_dir = 1'b0;
    req_src_addr = 64'h4000;
    req_dst_addr = 64'h9000;
    req_len = 32'd12288;
    h2c_dsc_byp_ready_0 = 1'b1;
    @(negedge axi_aclk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (h2c_dsc_byp_load_0 !== 1'b1 || h2c_dsc_byp_len_0 !== 28'd4096 ||
        h2c_dsc_byp_src_addr_0 !== 64'h4000) begin
      failures++;
      $display("[TB] FAIL reset_mid first: load=%b len=%0d src=%h, need 1 4096 4000",
               h2c_dsc_byp_load_0, h2c_dsc_byp_len_0, h2c_dsc_byp_src_addr_0);
    end
    @(negedge axi_aclk);
    axi_areset = 1'b1;
    #1;
    checks++;
    if (h2c_dsc_byp_load_0 !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid during: load=%b req_ready=%b, need 0 0",
               h2c_dsc_byp_load_0, req_ready);
    end
    @(negedge axi_aclk);
    axi_areset = 1'b0;
    model_h2c = '0;
    model_c2h = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_idle_outputs("reset_mid after");
      checks++;
      if (h2c_dsc_byp_len_0 !== 28'd0 || h2c_dsc_byp_src_addr_0 !== 64'd0) begin
        failures++;
        $display("[TB] FAIL reset_mid fields: len=%0d src=%h, need 0 0",
                 h2c_dsc_byp_len_0, h2c_dsc_byp_src_addr_0);
      end
      @(negedge axi_aclk);
    end
    h2c_dsc_byp_ready_0 = 1'b0;
    run_request(1'b0, 64'h5000, 64'h6000, 32'd5000, 0, "reset_mid fresh");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      run_request(1'b0, {32'h0, $urandom}, {32'h1, $urandom}, 32'($urandom_range(1, MAX_CHUNK)),
                  0, "wrap");
    end
    checks++;
    if (h2c_desc_cnt !== 4'd1) begin
      failures++;
      $display("[TB] FAIL wrap final: h2c_desc_cnt=%0d, need 1", h2c_desc_cnt);
    end
  endtask

  task automatic test_random();
    logic [63:0] s, t;
    logic [31:0] len;
    for (int i = 0; i < 12; i++) begin
      s = {$urandom, $urandom};
      t = {$urandom, $urandom};
      if (i % 4 == 0) s = {32'hFFFF_FFFF, 32'hFFFF_F000 + 32'($urandom_range(0, 4095))};
      if (i % 3 == 0) len = 32'(MAX_CHUNK * $urandom_range(1, 4));
      else            len = 32'($urandom_range(1, 20000));
      run_request(1'($urandom_range(0, 1)), s, t, len, 1, "random");
    end
  endtask

  initial begin
    $display("[TB] xdma_dsc_byp_issuer bench start");
    test_reset();
    test_single_h2c();
    test_multi_c2h();
    test_stall();
    test_zero_len();
    test_random();
    test_reset_mid_issue();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xdma_dsc_byp_issuer.md
Name: xdma_dsc_byp_issuer

Overview:
Drives the XDMA channel-0 descriptor-bypass inputs (h2c_dsc_byp_* / c2h_dsc_byp_*) from a simple user copy-request stream, acting as the descriptor source the DMA engine consumes. Each request (direction, source, destination, byte length) is split into descriptors of at most MAX_CHUNK bytes, issued with the bypass ready/load handshake. The last descriptor of each request is marked EOP and completed. Sits between the virtio queue logic and the xdma_xc7 wrapper in the axi_aclk domain.

Parameters:
MAX_CHUNK, 4096, max bytes per descriptor; 1..2^28-1
CNT_W, 16, width of per-direction issued-descriptor counters

Ports:
axi_aclk  in  1  clock; all logic is in this domain
axi_areset  in  1  synchronous, active-high reset
req_valid  in  1  copy request valid
req_ready  out  1  issuer can accept a request
req_dir  in  1  0 = H2C, 1 = C2H
req_src_addr  in  64  source byte address
req_dst_addr  in  64  destination byte address
req_len  in  32  total bytes; 0 is illegal
req_done  out  1  1-cycle pulse: last descriptor of the request loaded
req_err  out  1  1-cycle pulse: zero-length request dropped
h2c_dsc_byp_ready_0  in  1  engine accepts an H2C descriptor
h2c_dsc_byp_load_0  out  1  H2C descriptor load strobe
h2c_dsc_byp_src_addr_0  out  64  H2C src
h2c_dsc_byp_dst_addr_0  out  64  H2C dst
h2c_dsc_byp_len_0  out  28  H2C length
h2c_dsc_byp_ctl_0  out  16  H2C control
c2h_dsc_byp_ready_0 / load_0 / src_addr_0 / dst_addr_0 / len_0 / ctl_0  same as H2C, C2H channel
busy  out  1  request in progress
h2c_desc_cnt  out  CNT_W  descriptors loaded on H2C, wraps
c2h_desc_cnt  out  CNT_W  descriptors loaded on C2H, wraps

Behaviour:
- Reset: state IDLE; req_ready=1 after reset deasserts (0 during reset); req_done, req_err, both load strobes, busy = 0; all addr/len/ctl outputs = 0; counters = 0.
- FSM IDLE -> ISSUE -> IDLE.
- IDLE: req_ready=1. On req_valid&&req_len!=0: latch dir, src, dst, rem=req_len; go ISSUE next cycle. On req_valid&&req_len==0: accept, pulse req_err next cycle, stay IDLE, no load.
- ISSUE: req_ready=0, busy=1. Selected channel's fields are registered: len = min(rem, MAX_CHUNK); ctl[0] stop=0; ctl[1] completed = last; ctl[4] EOP = last; other ctl bits 0; last = (rem <= MAX_CHUNK).
- Load: load = (state==ISSUE) && selected ready, combinational from registered state. Load is never high while ready=0. Non-selected channel load stays 0, and its fields hold 0.
- On a load cycle: src += chunk, dst += chunk (64-bit, wrap modulo 2^64), rem -= chunk, selected counter += 1. If last, go IDLE and pulse req_done in the same cycle as the load.
- Latency: request accepted in cycle N gives first load at earliest N+1. Back-to-back loads are possible every cycle while ready stays high. A new request can be accepted in the cycle after req_done.
- req_len > MAX_CHUNK*k splits into ceil(len/MAX_CHUNK) descriptors. The final chunk holds the remainder; an exact multiple ends with a full chunk, never a zero-length descriptor.
- Ready drops mid-request: hold all fields, resume when ready returns. No timeout.
- axi_areset mid-ISSUE: abandon the request; no further load; outputs return to reset values next cycle.
- Counters wrap from 2^CNT_W-1 to 0.

Decomposition:
- Package xdma_byp_pkg: DIR_H2C/DIR_C2H constants, CTL_STOP_BIT=0, CTL_CMPL_BIT=1, CTL_EOP_BIT=4, DSC_LEN_W=28, and a struct typedef for a descriptor {src, dst, len, ctl}.
- One sub-module, xdma_dsc_chunker: holds rem/src/dst and computes chunk, last, and next addresses. The top holds the FSM, handshake, counters and the channel mux.

Test Plan:
- H2C request src=0x1000, dst=0x0, len=100, ready held 1: exactly one H2C load at N+1, len=100, ctl=0x0012, req_done in the same cycle; h2c_desc_cnt=1; c2h load never high.
- C2H request len=10000, MAX_CHUNK=4096, src=0x0, dst=0x8000_0000: three loads with len 4096/4096/1808; dst 0x8000_0000/0x8000_1000/0x8000_2000; ctl 0x0000, 0x0000, 0x0012.
- H2C request len=8192, ready toggled 1,0,0,1: two loads of 4096 only in cycles where ready=1, fields stable across the stall; last load has ctl=0x0012; no zero-length descriptor.
- req_len=0: req_err pulses once, no load, req_ready stays 1, counters unchanged.
- axi_areset asserted between the 1st and 2nd descriptor of a len=12288 request: no further loads, busy=0, counters=0; a fresh request afterwards issues normally.
- 2^CNT_W+1 single-chunk H2C requests: h2c_desc_cnt wraps to 1; req_ready low only during ISSUE.
